// File: rtl/video_ctrl_pkg.sv
// Shared register map, bit positions and reset values for the video control block.
package video_ctrl_pkg;

  localparam logic [4:0] ADDR_CTRL      = 5'h00;
  localparam logic [4:0] ADDR_STATUS    = 5'h04;
  localparam logic [4:0] ADDR_FG        = 5'h08;
  localparam logic [4:0] ADDR_BG        = 5'h0C;
  localparam logic [4:0] ADDR_LINE_CMP  = 5'h10;
  localparam logic [4:0] ADDR_FRAME_CNT = 5'h14;
  localparam logic [4:0] ADDR_SCRATCH   = 5'h18;

  localparam int CTRL_DISPLAY_EN  = 0;
  localparam int CTRL_VBLANK_IE   = 1;
  localparam int CTRL_LINE_IE     = 2;

  localparam int STAT_VBLANK_PEND = 0;
  localparam int STAT_LINE_PEND   = 1;
  localparam int STAT_IN_VBLANK   = 2;

  typedef logic [11:0] rgb444_t;

  localparam logic [2:0] CTRL_RST = 3'b001;
  localparam rgb444_t    FG_RST   = 12'hFFF;
  localparam rgb444_t    BG_RST   = 12'h000;

  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_e;

endpackage

// File: rtl/scan_event_detect.sv
// Turns scan-counter matches into single-cycle frame/line event pulses.
// Line event logic exists only when VIDEO_CTRL_LINE_IRQ_EN is defined.
module scan_event_detect #(
  parameter int HSZ    = 10,
  parameter int VSZ    = 9,
  parameter int H_LAST = 639,
  parameter int V_LAST = 479
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic [VSZ-1:0] i_scan_row,
  input  logic [HSZ-1:0] i_scan_column,
`ifdef VIDEO_CTRL_LINE_IRQ_EN
  input  logic [VSZ-1:0] i_line_cmp,
  output logic           o_line_evt,
`endif
  output logic           o_frame_evt
);

  logic w_col_last;
  logic w_frame_hit;
  logic r_frame_hit_q;

  assign w_col_last  = (i_scan_column == HSZ'(H_LAST));
  assign w_frame_hit = w_col_last & (i_scan_row == VSZ'(V_LAST));

  // Pulse only on the first cycle of a match so a stalled column counts once.
  assign o_frame_evt = w_frame_hit & ~r_frame_hit_q;

  // NOTE: async reset and non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_frame_hit_q <= 1'b0;
    else         r_frame_hit_q <= w_frame_hit;
  end

`ifdef VIDEO_CTRL_LINE_IRQ_EN
  logic w_line_hit;
  logic r_line_hit_q;

  assign w_line_hit = w_col_last & (i_scan_row == i_line_cmp);
  assign o_line_evt = w_line_hit & ~r_line_hit_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_line_hit_q <= 1'b0;
    else         r_line_hit_q <= w_line_hit;
  end
`endif

endmodule

// File: rtl/video_ctrl_regs.sv
// Video control register block: bus responder, frame/line event tracking and level IRQ.
// Optional line-compare interrupt enabled by defining VIDEO_CTRL_LINE_IRQ_EN.
module video_ctrl_regs
  import video_ctrl_pkg::*;
#(
  parameter int HSZ    = 10,
  parameter int VSZ    = 9,
  parameter int H_LAST = 639,
  parameter int V_LAST = 479
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_stb,
  input  logic           i_we,
  input  logic [4:0]     i_addr,
  input  logic [31:0]    i_data,
  output logic [31:0]    o_data,
  output logic           o_data_ready,
  input  logic [VSZ-1:0] i_scan_row,
  input  logic [HSZ-1:0] i_scan_column,
  output logic [11:0]    o_fg_color,
  output logic [11:0]    o_bg_color,
  output logic           o_display_en,
  output logic           o_irq
);

`ifdef VIDEO_CTRL_LINE_IRQ_EN
  localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
  localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif

  bus_state_e  r_state;
  logic        r_stb_q;
  logic [2:0]  r_ctrl;
  logic        r_vblank_pend;
  rgb444_t     r_fg;
  rgb444_t     r_bg;
  logic [31:0] r_frame_cnt;
  logic [31:0] r_scratch;
  logic        r_irq;

  logic        w_accept;
  logic        w_wr;
  logic [4:0]  w_addr;
  logic        w_unused_addr;
  logic        w_frame_evt;
  logic        w_line_pend;
  logic        w_in_vblank;
  logic [2:0]  w_status;
  logic [31:0] w_rdata;

  assign w_accept      = i_stb & ~r_stb_q;
  assign w_wr          = w_accept & i_we;
  assign w_addr        = {i_addr[4:2], 2'b00};
  assign w_unused_addr = ^i_addr[1:0];
  assign w_in_vblank   = (i_scan_row > VSZ'(V_LAST));

`ifdef VIDEO_CTRL_LINE_IRQ_EN
  logic [VSZ-1:0] r_line_cmp;
  logic           r_line_pend;
  logic           w_line_evt;

  scan_event_detect #(.HSZ(HSZ), .VSZ(VSZ), .H_LAST(H_LAST), .V_LAST(V_LAST)) u_evt (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_scan_row    (i_scan_row),
    .i_scan_column (i_scan_column),
    .i_line_cmp    (r_line_cmp),
    .o_line_evt    (w_line_evt),
    .o_frame_evt   (w_frame_evt)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_line_cmp  <= '0;
      r_line_pend <= 1'b0;
    end else begin
      if (w_wr && w_addr == ADDR_LINE_CMP) r_line_cmp <= i_data[VSZ-1:0];
      if (w_line_evt)                      r_line_pend <= 1'b1;
      else if (w_wr && w_addr == ADDR_STATUS && i_data[STAT_LINE_PEND])
        r_line_pend <= 1'b0;
    end
  end

  assign w_line_pend = r_line_pend;
`else
  scan_event_detect #(.HSZ(HSZ), .VSZ(VSZ), .H_LAST(H_LAST), .V_LAST(V_LAST)) u_evt (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_scan_row    (i_scan_row),
    .i_scan_column (i_scan_column),
    .o_frame_evt   (w_frame_evt)
  );

  assign w_line_pend = 1'b0;
`endif

  // NOTE: default-assign first so always_comb never infers a latch.
  always_comb begin
    w_status                   = '0;
    w_status[STAT_VBLANK_PEND] = r_vblank_pend;
    w_status[STAT_LINE_PEND]   = w_line_pend;
    w_status[STAT_IN_VBLANK]   = w_in_vblank;
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_CTRL:      w_rdata[2:0]  = r_ctrl;
      ADDR_STATUS:    w_rdata[2:0]  = w_status;
      ADDR_FG:        w_rdata[11:0] = r_fg;
      ADDR_BG:        w_rdata[11:0] = r_bg;
`ifdef VIDEO_CTRL_LINE_IRQ_EN
      ADDR_LINE_CMP:  w_rdata[VSZ-1:0] = r_line_cmp;
`else
      ADDR_LINE_CMP:  w_rdata = '0;
`endif
      ADDR_FRAME_CNT: w_rdata = r_frame_cnt;
      ADDR_SCRATCH:   w_rdata = r_scratch;
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_stb_q      <= 1'b0;
      r_state      <= BUS_IDLE;
      o_data       <= '0;
      o_data_ready <= 1'b0;
    end else begin
      r_stb_q <= i_stb;
      case (r_state)
        BUS_IDLE: begin
          if (w_accept) begin
            r_state      <= BUS_ACK;
            o_data_ready <= 1'b1;
            if (!i_we) o_data <= w_rdata;
          end
        end
        BUS_ACK: begin
          r_state      <= BUS_IDLE;
          o_data_ready <= 1'b0;
        end
        default: r_state <= BUS_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ctrl        <= CTRL_RST;
      r_vblank_pend <= 1'b0;
      r_fg          <= FG_RST;
      r_bg          <= BG_RST;
      r_frame_cnt   <= '0;
      r_scratch     <= '0;
      r_irq         <= 1'b0;
    end else begin
      if (w_wr && w_addr == ADDR_CTRL)    r_ctrl    <= i_data[2:0] & CTRL_WMASK;
      if (w_wr && w_addr == ADDR_FG)      r_fg      <= i_data[11:0];
      if (w_wr && w_addr == ADDR_BG)      r_bg      <= i_data[11:0];
      if (w_wr && w_addr == ADDR_SCRATCH) r_scratch <= i_data;

      // A new event outranks a simultaneous W1C; a count clear outranks a new event.
      if (w_frame_evt) r_vblank_pend <= 1'b1;
      else if (w_wr && w_addr == ADDR_STATUS && i_data[STAT_VBLANK_PEND])
        r_vblank_pend <= 1'b0;

      if (w_wr && w_addr == ADDR_FRAME_CNT) r_frame_cnt <= '0;
      else if (w_frame_evt)                 r_frame_cnt <= r_frame_cnt + 32'd1;

      r_irq <= (r_vblank_pend & r_ctrl[CTRL_VBLANK_IE])
             | (w_line_pend   & r_ctrl[CTRL_LINE_IE]);
    end
  end

  assign o_fg_color   = r_fg;
  assign o_bg_color   = r_bg;
  assign o_display_en = r_ctrl[CTRL_DISPLAY_EN];
  assign o_irq        = r_irq;

endmodule

// File: tb/tb_video_ctrl_regs.sv
// Directed self-checking bench for video_ctrl_regs; expectations follow the build's
// VIDEO_CTRL_LINE_IRQ_EN setting.
module tb_video_ctrl_regs;

  localparam logic [4:0] A_CTRL = 5'h00, A_STATUS = 5'h04, A_FG = 5'h08, A_BG = 5'h0C;
  localparam logic [4:0] A_LCMP = 5'h10, A_FCNT = 5'h14, A_SCR = 5'h18, A_UNMAP = 5'h1C;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stb, we;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ready;
  logic [8:0]  row;
  logic [9:0]  col;
  logic [11:0] fg, bg;
  logic        den, irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_ctrl_regs dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_stb         (stb),
    .i_we          (we),
    .i_addr        (addr),
    .i_data        (wdata),
    .o_data        (rdata),
    .o_data_ready  (ready),
    .i_scan_row    (row),
    .i_scan_column (col),
    .o_fg_color    (fg),
    .o_bg_color    (bg),
    .o_display_en  (den),
    .o_irq         (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns 1ns after the accept edge with ready checked.
  task automatic bus_start(input logic w, input logic [4:0] a, input logic [31:0] d);
    stb = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    check($sformatf("ack_rise@%0h", a), {31'b0, ready}, 32'd1);
  endtask

  task automatic bus_end(input logic [4:0] a);
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check($sformatf("ack_fall@%0h", a), {31'b0, ready}, 32'd0);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_start(1'b1, a, d);
    bus_end(a);
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] r;
    @(negedge clk);
    bus_start(1'b0, a, 32'd0);
    r = rdata;
    bus_end(a);
    check(tag, r, exp);
  endtask

  task automatic pulse_scan(input logic [8:0] r, input logic [9:0] c, input int cycles);
    @(negedge clk);
    row = r; col = c;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    row = '0; col = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    logic [31:0] r;
    rstn = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; row = '0; col = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_odata", rdata, 32'd0);
    check("rst_irq",   {31'b0, irq}, 32'd0);
    check("rst_fg",    {20'b0, fg}, 32'hFFF);
    check("rst_bg",    {20'b0, bg}, 32'h000);
    check("rst_den",   {31'b0, den}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    read_check("rd_ctrl",   A_CTRL,   32'h1);
    read_check("rd_status", A_STATUS, 32'h0);
    read_check("rd_fg",     A_FG,     32'hFFF);
    read_check("rd_bg",     A_BG,     32'h0);
    read_check("rd_lcmp",   A_LCMP,   32'h0);
    read_check("rd_fcnt",   A_FCNT,   32'h0);
    read_check("rd_scr",    A_SCR,    32'h0);

    // Colour writes land on the outputs at the accept edge.
    @(negedge clk);
    bus_start(1'b1, A_FG, 32'h0F0);
    check("fg_commit", {20'b0, fg}, 32'h0F0);
    bus_end(A_FG);
    @(negedge clk);
    bus_start(1'b1, A_BG, 32'hFFFF_F123);
    check("bg_commit", {20'b0, bg}, 32'h123);
    bus_end(A_BG);
    read_check("rb_fg", A_FG, 32'h0F0);
    read_check("rb_bg", A_BG, 32'h123);
    bus_write(A_SCR, 32'hDEAD_BEEF);
    read_check("rb_scr", A_SCR, 32'hDEAD_BEEF);
    bus_write(A_CTRL, 32'h0);
    check("den_off", {31'b0, den}, 32'd0);

    // Strobe held high for 5 cycles must yield a single ack.
    acks = 0;
    @(negedge clk);
    stb = 1'b1; we = 1'b0; addr = A_SCR;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready) acks++;
    end
    @(negedge clk);
    stb = 1'b0;
    @(posedge clk); #1;
    if (ready) acks++;
    check("held_stb_acks", acks, 32'd1);

    // Three frames, the first with the column stalled on the sample point.
    bus_write(A_CTRL, 32'h3);
    check("den_on", {31'b0, den}, 32'd1);
    pulse_scan(9'd479, 10'd639, 3);
    pulse_scan(9'd479, 10'd639, 1);
    pulse_scan(9'd479, 10'd639, 1);
    @(posedge clk); #1;
    check("irq_vblank", {31'b0, irq}, 32'd1);
    read_check("fcnt_3", A_FCNT, 32'd3);
    read_check("status_vpend", A_STATUS, 32'h1);
    @(negedge clk);
    row = 9'd480;
    bus_start(1'b0, A_STATUS, 32'd0);
    r = rdata;
    bus_end(A_STATUS);
    check("status_in_vblank", r, 32'h5);
    @(negedge clk);
    row = '0;

    // W1C: irq still high at the clearing edge, low one cycle later.
    @(negedge clk);
    bus_start(1'b1, A_STATUS, 32'h1);
    check("irq_before_clr", {31'b0, irq}, 32'd1);
    bus_end(A_STATUS);
    check("irq_after_clr", {31'b0, irq}, 32'd0);
    read_check("status_clr", A_STATUS, 32'h0);

    // FRAME_CNT write on the same edge as a frame event: the clear wins.
    @(negedge clk);
    row = 9'd479; col = 10'd639;
    bus_start(1'b1, A_FCNT, 32'h1234);
    bus_end(A_FCNT);
    @(negedge clk);
    row = '0; col = '0;
    read_check("fcnt_race", A_FCNT, 32'd0);
    read_check("vpend_race_set", A_STATUS, 32'h1);

    // W1C on the same edge as a frame event: the set wins.
    @(negedge clk);
    row = 9'd479; col = 10'd639;
    bus_start(1'b1, A_STATUS, 32'h1);
    bus_end(A_STATUS);
    @(negedge clk);
    row = '0; col = '0;
    read_check("vpend_w1c_race", A_STATUS, 32'h1);
    read_check("fcnt_after_race", A_FCNT, 32'd1);
    bus_write(A_STATUS, 32'h3);
    read_check("status_clr2", A_STATUS, 32'h0);

    bus_write(A_CTRL, 32'h5);
    bus_write(A_LCMP, 32'd100);
`ifdef VIDEO_CTRL_LINE_IRQ_EN
    read_check("lcmp_rb", A_LCMP, 32'd100);
    read_check("ctrl_line_ie", A_CTRL, 32'h5);
    pulse_scan(9'd100, 10'd639, 1);
    @(posedge clk); #1;
    check("irq_line", {31'b0, irq}, 32'd1);
    read_check("status_lpend", A_STATUS, 32'h2);
    @(negedge clk);
    row = 9'd100; col = 10'd639;
    bus_start(1'b1, A_STATUS, 32'h2);
    bus_end(A_STATUS);
    @(negedge clk);
    row = '0; col = '0;
    read_check("lpend_w1c_race", A_STATUS, 32'h2);
    bus_write(A_STATUS, 32'h2);
    check("irq_line_clr", {31'b0, irq}, 32'd0);
    read_check("status_lclr", A_STATUS, 32'h0);
`else
    read_check("lcmp_absent", A_LCMP, 32'd0);
    read_check("ctrl_no_line_ie", A_CTRL, 32'h1);
    pulse_scan(9'd100, 10'd639, 1);
    @(posedge clk); #1;
    check("irq_no_line", {31'b0, irq}, 32'd0);
    read_check("status_no_lpend", A_STATUS, 32'h0);
`endif

    read_check("unmapped_rd", A_UNMAP, 32'd0);
    bus_write(A_UNMAP, 32'hFFFF_FFFF);
    read_check("scr_after_unmap_wr", A_SCR, 32'hDEAD_BEEF);

    // Reset asserted while the ack is showing.
    @(negedge clk);
    bus_start(1'b1, A_FG, 32'hABC);
    check("fg_pre_reset", {20'b0, fg}, 32'hABC);
    #1 rstn = 1'b0;
    #1;
    check("rst_abort_ready", {31'b0, ready}, 32'd0);
    check("rst_abort_fg",    {20'b0, fg}, 32'hFFF);
    check("rst_abort_bg",    {20'b0, bg}, 32'h000);
    check("rst_abort_den",   {31'b0, den}, 32'd1);
    check("rst_abort_odata", rdata, 32'd0);
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    read_check("post_rst_fcnt", A_FCNT,   32'd0);
    read_check("post_rst_scr",  A_SCR,    32'd0);
    read_check("post_rst_ctrl", A_CTRL,   32'h1);
    read_check("post_rst_lcmp", A_LCMP,   32'd0);
    read_check("post_rst_stat", A_STATUS, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
